// File: rtl/mult_pkg.sv
// Shared FSM encoding and default widths for the product accumulator.
package mult_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam int unsigned DEF_PROD_W = 32;
    localparam int unsigned DEF_ACC_W  = 40;
    localparam int unsigned DEF_LEN    = 8;
    localparam int unsigned CNT_W      = 8;

endpackage

// File: rtl/sat_adder.sv
// W-bit adder; with SAT set, a carry-out clamps the sum to all ones.
module sat_adder #(
    parameter int unsigned W   = 40,
    parameter bit          SAT = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum_c,
    output logic         clamped_c
);

    logic [W:0] full;

    assign full      = {1'b0, a} + {1'b0, b};
    assign clamped_c = SAT && full[W];
    assign sum_c     = clamped_c ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates LEN products (or fewer on flush) into one result with a valid/ready handshake.
// Define PROD_ACC_SAT_EN to saturate the sum on carry-out and report overflow; otherwise it wraps.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned LEN    = DEF_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  acc_count,
    output logic              overflow
);

`ifdef PROD_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t            state;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  add_sum;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  next_count;
    logic              clamped;
    logic              accept;
    logic              close_sum;

    sat_adder #(
        .W   (ACC_W),
        .SAT (SAT_EN)
    ) u_sat_adder (
        .a         (sum),
        .b         (ACC_W'(prod_in)),
        .sum_c     (add_sum),
        .clamped_c (clamped)
    );

    // Close on the LEN-th accept, or on flush once at least one product is held.
    assign accept     = prod_valid && prod_ready;
    assign next_count = count + CNT_W'(accept);
    assign close_sum  = (accept && (next_count == CNT_W'(LEN))) ||
                        (flush && (next_count != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ACCUM;
            sum        <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            prod_ready <= 1'b1;
            acc_valid  <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        sum      <= add_sum;
                        count    <= next_count;
                        overflow <= overflow | clamped;
                    end
                    if (close_sum) begin
                        state      <= ST_DONE;
                        prod_ready <= 1'b0;
                        acc_valid  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (acc_ready) begin
                        state      <= ST_ACCUM;
                        sum        <= '0;
                        count      <= '0;
                        overflow   <= 1'b0;
                        prod_ready <= 1'b1;
                        acc_valid  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_ACCUM;
                    prod_ready <= 1'b1;
                    acc_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_out   = sum;
    assign acc_count = count;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: default-width instance plus a 34-bit accumulator for the wrap/saturate case.
module tb_product_accumulator;

    typedef struct {
        logic [39:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic        flush;
    logic [39:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic [7:0]  acc_count;
    logic        overflow;

    logic [31:0] p2_in;
    logic        p2_valid;
    logic        p2_ready;
    logic        p2_flush;
    logic [33:0] a2_out;
    logic        a2_valid;
    logic        a2_ready;
    logic [7:0]  a2_count;
    logic        a2_ovf;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb_q[$];
    bit   seen = 0;

    product_accumulator #(.PROD_W(32), .ACC_W(40), .LEN(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .flush      (flush),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_count  (acc_count),
        .overflow   (overflow)
    );

    product_accumulator #(.PROD_W(32), .ACC_W(34), .LEN(8)) dut34 (
        .clk        (clk),
        .reset      (reset),
        .prod_in    (p2_in),
        .prod_valid (p2_valid),
        .prod_ready (p2_ready),
        .flush      (p2_flush),
        .acc_out    (a2_out),
        .acc_valid  (a2_valid),
        .acc_ready  (a2_ready),
        .acc_count  (a2_count),
        .overflow   (a2_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare each new result against the oldest expected entry.
    always @(negedge clk) begin
        if (acc_valid && !seen) begin
            exp_t e;
            seen = 1;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fails++;
                $display("FAIL sb_unexpected: acc_valid with empty queue, acc_out=%0d", acc_out);
            end else begin
                e = sb_q.pop_front();
                if (acc_out !== e.acc) begin
                    n_fails++;
                    $display("FAIL sb_acc_out: got %0d expected %0d", acc_out, e.acc);
                end
                n_checks++;
                if (acc_count !== e.cnt) begin
                    n_fails++;
                    $display("FAIL sb_acc_count: got %0d expected %0d", acc_count, e.cnt);
                end
                n_checks++;
                if (overflow !== e.ovf) begin
                    n_fails++;
                    $display("FAIL sb_overflow: got %0b expected %0b", overflow, e.ovf);
                end
            end
        end
        if (!acc_valid) seen = 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic fl);
        int n = 0;
        prod_in    = v;
        prod_valid = 1'b1;
        flush      = fl;
        while (!prod_ready && n < 50) begin
            step();
            n++;
        end
        if (!prod_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: prod_ready=%0b expected 1", prod_ready);
        end
        step();
        prod_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic send2(input logic [31:0] v);
        int n = 0;
        p2_in    = v;
        p2_valid = 1'b1;
        while (!p2_ready && n < 50) begin
            step();
            n++;
        end
        if (!p2_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send2_timeout: prod_ready=%0b expected 1", p2_ready);
        end
        step();
        p2_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        n_checks++;
        if (prod_ready !== 1'b1 || acc_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_handshake: ready=%0b valid=%0b expected 1/0", prod_ready, acc_valid);
        end
        n_checks++;
        if (acc_out !== 40'd0 || acc_count !== 8'd0 || overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state: out=%0d cnt=%0d ovf=%0b expected 0/0/0", acc_out, acc_count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{acc: 40'd520200, cnt: 8'd8, ovf: 1'b0});
        for (int i = 0; i < 7; i++) send(32'd65025, 1'b0);
        n_checks++;
        if (acc_valid !== 1'b0 || acc_count !== 8'd7 || acc_out !== 40'd455175) begin
            n_fails++;
            $display("FAIL b2b_running: valid=%0b cnt=%0d out=%0d expected 0/7/455175", acc_valid, acc_count, acc_out);
        end
        send(32'd65025, 1'b0);
        n_checks++;
        if (acc_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_latency: acc_valid=%0b expected 1 one cycle after 8th accept", acc_valid);
        end
        step();
    endtask

    task automatic test_toggle_valid();
        sb_q.push_back('{acc: 40'd131072, cnt: 8'd8, ovf: 1'b0});
        acc_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'd16384, 1'b0);
            if (i != 7) step();
        end
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1;
            n_checks++;
            if (prod_ready !== 1'b0 || acc_valid !== 1'b1) begin
                n_fails++;
                $display("FAIL toggle_done_ready: prod_ready=%0b acc_valid=%0b expected 0/1", prod_ready, acc_valid);
            end
            step();
        end
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        step();
        step();
    endtask

    task automatic test_stall();
        sb_q.push_back('{acc: 40'd520200, cnt: 8'd8, ovf: 1'b0});
        acc_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'd65025, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (acc_valid !== 1'b1 || acc_out !== 40'd520200 || acc_count !== 8'd8) begin
                n_fails++;
                $display("FAIL stall_hold%0d: valid=%0b out=%0d cnt=%0d expected 1/520200/8", i, acc_valid, acc_out, acc_count);
            end
            if (i == 3) acc_ready = 1'b1;
            step();
        end
        n_checks++;
        if (acc_valid !== 1'b0 || prod_ready !== 1'b1 || acc_out !== 40'd0 || acc_count !== 8'd0) begin
            n_fails++;
            $display("FAIL stall_reenter: valid=%0b ready=%0b out=%0d cnt=%0d expected 0/1/0/0", acc_valid, prod_ready, acc_out, acc_count);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        repeat (2) step();
        flush = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0 || prod_ready !== 1'b1 || acc_count !== 8'd0) begin
            n_fails++;
            $display("FAIL flush_empty: valid=%0b ready=%0b cnt=%0d expected 0/1/0", acc_valid, prod_ready, acc_count);
        end
        sb_q.push_back('{acc: 40'd375, cnt: 8'd3, ovf: 1'b0});
        send(32'd125, 1'b0);
        send(32'd125, 1'b0);
        send(32'd125, 1'b1);
        n_checks++;
        if (acc_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_close: acc_valid=%0b expected 1", acc_valid);
        end
        step();
    endtask

    task automatic test_wrap_saturate();
        logic [33:0] exp_out;
        logic        exp_ovf;
        int          n = 0;
`ifdef PROD_ACC_SAT_EN
        exp_out = 34'h3FFFFFFFF;
        exp_ovf = 1'b1;
`else
        exp_out = 34'h3FFFFFFF8;
        exp_ovf = 1'b0;
`endif
        a2_ready = 1'b0;
        for (int i = 0; i < 8; i++) send2(32'hFFFFFFFF);
        while (!a2_valid && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (a2_valid !== 1'b1 || a2_out !== exp_out || a2_count !== 8'd8) begin
            n_fails++;
            $display("FAIL acc34_result: valid=%0b out=%0d cnt=%0d expected 1/%0d/8", a2_valid, a2_out, a2_count, exp_out);
        end
        n_checks++;
        if (a2_ovf !== exp_ovf) begin
            n_fails++;
            $display("FAIL acc34_overflow: got %0b expected %0b", a2_ovf, exp_ovf);
        end
        a2_ready = 1'b1;
        step();
        n_checks++;
        if (a2_ovf !== 1'b0 || a2_out !== 34'd0 || a2_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL acc34_consume: ovf=%0b out=%0d valid=%0b expected 0/0/0", a2_ovf, a2_out, a2_valid);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) send(32'd7, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0 || acc_count !== 8'd0 || acc_out !== 40'd0) begin
            n_fails++;
            $display("FAIL midreset_clear: valid=%0b cnt=%0d out=%0d expected 0/0/0", acc_valid, acc_count, acc_out);
        end
        sb_q.push_back('{acc: 40'd8, cnt: 8'd8, ovf: 1'b0});
        for (int i = 0; i < 8; i++) send(32'd1, 1'b0);
        step();
        step();
    endtask

    initial begin
        reset      = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        flush      = 1'b0;
        acc_ready  = 1'b1;
        p2_in      = '0;
        p2_valid   = 1'b0;
        p2_flush   = 1'b0;
        a2_ready   = 1'b1;
        step();

        test_reset();
        test_back_to_back();
        test_toggle_valid();
        test_stall();
        test_flush();
        test_wrap_saturate();
        test_mid_reset();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL sb_drain: %0d results never produced, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 32, width of each incoming multiplier product.
REQ-002 SHALL have parameter ACC_W, default 40, accumulator width; ACC_W >= PROD_W.
REQ-003 SHALL have parameter LEN, default 8, products per accumulated result; 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port prod_in  input  PROD_W  unsigned product from the upstream multiplier.
REQ-007 SHALL have port prod_valid  input  1  prod_in is valid this cycle.
REQ-008 SHALL have port prod_ready  output  1  block accepts prod_in this cycle.
REQ-009 SHALL have port flush  input  1  close the current sum early.
REQ-010 SHALL have port acc_out  output  ACC_W  accumulated result.
REQ-011 SHALL have port acc_valid  output  1  acc_out is valid.
REQ-012 SHALL have port acc_ready  input  1  downstream consumes acc_out.
REQ-013 SHALL have port acc_count  output  8  number of products in acc_out or in the running sum.
REQ-014 SHALL have port overflow  output  1  result saturated (see Configuration).

Function
REQ-015 SHALL implement a two-state FSM: ACCUM (prod_ready=1, acc_valid=0) and DONE (prod_ready=0, acc_valid=1).
REQ-016 SHALL accept a product only on a cycle with prod_valid && prod_ready; sum += zero-extended prod_in; count += 1.
REQ-017 SHALL go ACCUM->DONE on the edge where the LEN-th product is accepted; acc_valid SHALL be high in the next cycle (latency 1 cycle after the last accept).
REQ-018 SHALL go ACCUM->DONE when flush=1 and the count after this cycle's accept is >= 1; a product accepted in the same cycle is included.
REQ-019 SHALL ignore flush when count is 0 and no product is accepted that cycle; SHALL ignore flush in DONE.
REQ-020 SHALL hold acc_out, acc_count and overflow stable while acc_valid=1 and acc_ready=0.
REQ-021 SHALL go DONE->ACCUM on acc_valid && acc_ready; on that edge sum, count and overflow clear to 0. No product is accepted in that cycle.
REQ-022 SHALL, in ACCUM, drive acc_out with the running sum and acc_count with the running count; these are informational only.
REQ-023 SHALL, without saturation, wrap modulo 2^ACC_W.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, enter ACCUM with sum=0, count=0, overflow=0, acc_valid=0, prod_ready=1 next cycle.
REQ-025 SHALL discard any partial or pending result on a mid-operation reset; reset has priority over all other inputs.

Configuration
REQ-026 SHALL, when macro PROD_ACC_SAT_EN is defined, clamp the sum to 2^ACC_W-1 when an add carries out, and set overflow=1 until the result is consumed or reset.
REQ-027 SHALL, when PROD_ACC_SAT_EN is undefined, wrap per REQ-023 and tie overflow to constant 0.

Structure
REQ-028 SHALL place the FSM state encoding (ST_ACCUM, ST_DONE) and default-width constants in shared package mult_pkg.
REQ-029 SHALL be a single module; the optional saturating adder MAY be sub-module sat_adder (ACC_W-bit a+b, carry-out clamp).

Verification
REQ-030 SHALL check: LEN=8, eight products 65025 back-to-back -> acc_out=520200, acc_count=8, acc_valid one cycle after the 8th accept.
REQ-031 SHALL check: eight products 16384 with prod_valid toggling every other cycle -> acc_out=131072; prod_ready=0 throughout DONE.
REQ-032 SHALL check: result 520200 with acc_ready held low 3 cycles -> acc_out stable for 4 cycles; ACCUM re-entered with sum 0 after the consume edge.
REQ-033 SHALL check: products 125, 125, 125, with flush on the third accept -> acc_out=375, acc_count=3.
REQ-034 SHALL check: ACC_W=34, eight products 0xFFFFFFFF -> with PROD_ACC_SAT_EN acc_out=17179869183, overflow=1; without it acc_out=0x7FFFFFFF8 mod 2^34, overflow=0.
REQ-035 SHALL check: reset after 5 of 8 products -> no acc_valid; the next 8 products of 1 give acc_out=8.
